// File: rtl/task_scheduler.sv
// task_scheduler: picks the highest-priority ready task, dispatches it for
// QUANTUM cycles on the shared op bus, and lets host commands use idle slots.
// Ports: CLK, RST (async, active-low), task_status (16b per slot: id|prio),
//   host_op/host_valid/host_ready (host command handshake), op_out/op_valid
//   (registered op bus), cur_id (running task id), busy (scheduler active).
// Optional: define TASK_SCHED_AGING_EN to add per-slot starvation aging.
module task_scheduler #(
    parameter int N_TASKS   = 8,
    parameter int QUANTUM   = 16,
    parameter int AGE_LIMIT = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [16*N_TASKS-1:0]  task_status,
    input  logic [15:0]            host_op,
    input  logic                   host_valid,
    output logic                   host_ready,
    output logic [15:0]            op_out,
    output logic                   op_valid,
    output logic [3:0]             cur_id,
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_DISPATCH, S_RUN, S_FINISH
    } state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_slot;
    logic [7:0]  r_id;
    logic [7:0]  r_pri;
    logic [15:0] r_qcnt;

    logic        w_any;
    logic [3:0]  w_win_slot;
    logic [7:0]  w_win_id;
    logic [7:0]  w_win_pri;
    logic [7:0]  w_run_id;
    logic        w_abort;
    logic [15:0] w_op_nxt;
    logic        w_opv_nxt;
    logic [3:0]  w_cur_nxt;

`ifdef TASK_SCHED_AGING_EN
    logic [3:0]  r_age [N_TASKS];
    logic        w_aged;
`endif

    // Strict '>' while scanning upward keeps ties on the lowest slot.
    always_comb begin
        w_any      = 1'b0;
        w_win_slot = '0;
        w_win_id   = '0;
        w_win_pri  = '0;
        for (int k = 0; k < N_TASKS; k++) begin
            if (task_status[16*k+8 +: 8] != 8'h00) begin
                if (!w_any || task_status[16*k +: 8] > w_win_pri) begin
                    w_any      = 1'b1;
                    w_win_slot = 4'(k);
                    w_win_id   = task_status[16*k+8 +: 8];
                    w_win_pri  = task_status[16*k +: 8];
                end
            end
        end
`ifdef TASK_SCHED_AGING_EN
        // A starved slot overrides priority; first aged slot wins.
        w_aged = 1'b0;
        for (int k = 0; k < N_TASKS; k++) begin
            if (!w_aged && task_status[16*k+8 +: 8] != 8'h00
                && int'(r_age[k]) >= AGE_LIMIT) begin
                w_aged     = 1'b1;
                w_win_slot = 4'(k);
                w_win_id   = task_status[16*k+8 +: 8];
                w_win_pri  = task_status[16*k +: 8];
            end
        end
`endif
    end

    // The running task is tracked by slot; any id change there ends it.
    assign w_run_id   = task_status[16*int'(r_slot)+8 +: 8];
    assign w_abort    = (w_run_id != r_id);
    assign host_ready = (r_state != S_DISPATCH) && (r_state != S_FINISH);

    always_comb begin
        w_next    = r_state;
        w_op_nxt  = 16'h0000;
        w_opv_nxt = 1'b0;
        w_cur_nxt = cur_id;
        if (host_valid && host_ready) begin
            w_op_nxt  = host_op;
            w_opv_nxt = 1'b1;
        end
        unique case (r_state)
            S_IDLE: begin
                if (w_any) w_next = S_SELECT;
            end
            S_SELECT: begin
                w_next = w_any ? S_DISPATCH : S_IDLE;
            end
            S_DISPATCH: begin
                w_op_nxt  = {4'h0, r_id[3:0], 4'h7, 4'h0};
                w_opv_nxt = 1'b1;
                w_cur_nxt = r_id[3:0];
                w_next    = S_RUN;
            end
            S_RUN: begin
                if (w_abort) begin
                    w_cur_nxt = 4'h0;
                    w_next    = S_IDLE;
                end else if (r_qcnt == 16'(QUANTUM - 1)) begin
                    w_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_op_nxt  = {4'h0, r_id[3:0], 4'hF, 4'h0};
                w_opv_nxt = 1'b1;
                w_cur_nxt = 4'h0;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= S_IDLE;
            r_slot   <= '0;
            r_id     <= '0;
            r_pri    <= '0;
            r_qcnt   <= '0;
            op_out   <= '0;
            op_valid <= 1'b0;
            cur_id   <= '0;
            busy     <= 1'b0;
        end else begin
            r_state  <= w_next;
            op_out   <= w_op_nxt;
            op_valid <= w_opv_nxt;
            cur_id   <= w_cur_nxt;
            busy     <= (w_next == S_DISPATCH) || (w_next == S_RUN)
                        || (w_next == S_FINISH);
            if (r_state == S_SELECT && w_any) begin
                r_slot <= w_win_slot;
                r_id   <= w_win_id;
                r_pri  <= w_win_pri;
            end
            if (r_state == S_DISPATCH) r_qcnt <= '0;
            else if (r_state == S_RUN) r_qcnt <= r_qcnt + 16'd1;
        end
    end

`ifdef TASK_SCHED_AGING_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k < N_TASKS; k++) r_age[k] <= '0;
        end else if (r_state == S_SELECT && w_any) begin
            for (int k = 0; k < N_TASKS; k++) begin
                if (task_status[16*k+8 +: 8] == 8'h00)
                    r_age[k] <= '0;
                else if (4'(k) == w_win_slot)
                    r_age[k] <= '0;
                else if (r_age[k] != 4'hF)
                    r_age[k] <= r_age[k] + 4'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_task_scheduler.sv
// Directed bench for task_scheduler with an op-bus scoreboard.
// Expected ops are queued by the stimulus and checked by a monitor.
module tb_task_scheduler;

    localparam int N = 8;
    localparam int Q = 8;
    localparam int AL = 3;

    logic          CLK;
    logic          RST;
    logic [16*N-1:0] task_status;
    logic [15:0]   host_op;
    logic          host_valid;
    logic          host_ready;
    logic [15:0]   op_out;
    logic          op_valid;
    logic [3:0]    cur_id;
    logic          busy;

    int n_cmp;
    int n_bad;
    logic [15:0] exp_q[$];

    task_scheduler #(
        .N_TASKS(N), .QUANTUM(Q), .AGE_LIMIT(AL)
    ) dut (
        .CLK(CLK), .RST(RST), .task_status(task_status),
        .host_op(host_op), .host_valid(host_valid),
        .host_ready(host_ready), .op_out(op_out),
        .op_valid(op_valid), .cur_id(cur_id), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every op pulse must match the next queued expectation.
    always @(negedge CLK) begin
        if (RST && op_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_op: got %04h expected none",
                         op_out);
            end else begin
                chk("op_bus", int'(op_out), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic set_slot(input int k, input logic [15:0] v);
        task_status[16*k +: 16] = v;
    endtask

    task automatic wait_cur(input logic [3:0] id, input string nm);
        int i;
        i = 0;
        do begin
            @(negedge CLK);
            i++;
        end while (cur_id != id && i < 200);
        chk(nm, int'(cur_id), int'(id));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int bad;
        logic last_hr;
        logic busy_ok;
        n_cmp = 0;
        n_bad = 0;
        RST = 1'b0;
        task_status = '0;
        host_op = '0;
        host_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_op_valid", int'(op_valid), 0);
        chk("rst_cur_id", int'(cur_id), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_host_ready", int'(host_ready), 1);
        RST = 1'b1;

        // Idle with no ready tasks
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (busy || !host_ready || cur_id != 0 || op_valid) bad++;
        end
        chk("idle_quiet", bad, 0);

        // Host op accepted in IDLE
        exp_q.push_back(16'h0A31);
        host_op = 16'h0A31;
        host_valid = 1'b1;
        @(negedge CLK);
        host_valid = 1'b0;
        host_op = '0;
        repeat (3) @(negedge CLK);

        // Single task, full quantum
        exp_q.push_back(16'h0970);
        exp_q.push_back(16'h09F0);
        set_slot(2, 16'h0905);
        wait_cur(4'd9, "dispatch_9");
        chk("run0_host_ready", int'(host_ready), 1);
        n = 0;
        busy_ok = 1'b1;
        last_hr = 1'b1;
        while (cur_id == 4'd9 && n < 100) begin
            n++;
            last_hr = host_ready;
            busy_ok = busy_ok & busy;
            @(negedge CLK);
        end
        set_slot(2, 16'h0000);
        // Q RUN cycles plus the FINISH cycle.
        chk("cur_id_cycles", n, Q + 1);
        chk("busy_held", int'(busy_ok), 1);
        chk("finish_host_ready", int'(last_hr), 0);
        chk("done_busy", int'(busy), 0);
        repeat (5) @(negedge CLK);

        // Tie goes to lowest slot, then raised priority wins
        exp_q.push_back(16'h0370);
        exp_q.push_back(16'h03F0);
        set_slot(1, 16'h0307);
        set_slot(4, 16'h0607);
        wait_cur(4'd3, "tie_id3");
        wait_cur(4'd0, "tie_done");
        exp_q.push_back(16'h0670);
        exp_q.push_back(16'h06F0);
        set_slot(4, 16'h0608);
        wait_cur(4'd6, "prio_id6");
        wait_cur(4'd0, "prio_done");
        task_status = '0;
        repeat (5) @(negedge CLK);

        // Abort when the running task goes away
        exp_q.push_back(16'h0970);
        set_slot(2, 16'h0905);
        wait_cur(4'd9, "abort_dispatch");
        repeat (5) @(negedge CLK);
        set_slot(2, 16'h0000);
        @(negedge CLK);
        chk("abort_cur_id", int'(cur_id), 0);
        chk("abort_busy", int'(busy), 0);
        repeat (30) @(negedge CLK);

        // Host op blocked in DISPATCH, accepted in first RUN cycle
        exp_q.push_back(16'h0970);
        exp_q.push_back(16'h0520);
        exp_q.push_back(16'h09F0);
        set_slot(2, 16'h0905);
        chk("hr_idle", int'(host_ready), 1);
        @(negedge CLK);
        chk("hr_select", int'(host_ready), 1);
        @(negedge CLK);
        chk("hr_dispatch", int'(host_ready), 0);
        host_valid = 1'b1;
        host_op = 16'h0520;
        @(negedge CLK);
        chk("hr_run0", int'(host_ready), 1);
        chk("run0_cur_id", int'(cur_id), 9);
        @(posedge CLK);
        #1;
        host_valid = 1'b0;
        host_op = '0;
        @(negedge CLK);
        chk("host_op_slot", int'(op_valid), 1);
        wait_cur(4'd0, "host_test_done");
        set_slot(2, 16'h0000);
        repeat (5) @(negedge CLK);

        // Reset in the middle of RUN
        exp_q.push_back(16'h0970);
        set_slot(2, 16'h0905);
        wait_cur(4'd9, "rst_dispatch");
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("midrst_cur_id", int'(cur_id), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_op_valid", int'(op_valid), 0);
        set_slot(2, 16'h0000);
        @(negedge CLK);
        RST = 1'b1;
        repeat (20) @(negedge CLK);

`ifdef TASK_SCHED_AGING_EN
        // Starved slot 0 gets every fourth dispatch
        for (int d = 0; d < 8; d++) begin
            if (d % 4 == 3) begin
                exp_q.push_back(16'h0170);
                exp_q.push_back(16'h01F0);
            end else begin
                exp_q.push_back(16'h0270);
                exp_q.push_back(16'h02F0);
            end
        end
        set_slot(0, 16'h0101);
        set_slot(1, 16'h02FF);
        for (int d = 0; d < 8; d++) begin
            wait_cur((d % 4 == 3) ? 4'd1 : 4'd2, "age_dispatch");
            wait_cur(4'd0, "age_done");
        end
        task_status = '0;
        repeat (10) @(negedge CLK);
`endif

        repeat (10) @(negedge CLK);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
